// File: rtl/cmd_proc_pkg.sv
// Shared types and constants for the cmd_proc command processor.
// Build option FAST_SIM_EN selects a coarse speed increment so ramps finish quickly.
package cmd_proc_pkg;

  typedef enum logic [3:0] {
    OP_CAL  = 4'h2,
    OP_HEAD = 4'h4
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    CAL,
    HEAD,
    RAMP_UP,
    RAMP_DN
  } state_e;

  localparam logic        [9:0]  FRWRD_MAX = 10'h2A0;
  localparam logic signed [11:0] HDNG_TOL  = 12'sh030;
  localparam logic        [7:0]  RESP_ACK  = 8'hA5;
  localparam logic        [7:0]  RESP_NACK = 8'h5A;

`ifdef FAST_SIM_EN
  localparam logic [9:0] FRWRD_INC = 10'h020;
`else
  localparam logic [9:0] FRWRD_INC = 10'h003;
`endif

  // Ramp down runs at twice the ramp-up rate.
  localparam logic [9:0] FRWRD_DEC = {FRWRD_INC[8:0], 1'b0};

  function automatic logic [11:0] hdng_decode(input logic [7:0] code);
    return (code == 8'h00) ? 12'h000 : {code, 4'hF};
  endfunction

endpackage

// File: rtl/cmd_line_cnt.sv
// Counts rising edges of the centre line sensor while enabled; clr restarts the count.
module cmd_line_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       cntr_ir,
  output logic [4:0] line_cnt
);

  logic cntr_ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntr_ir_q <= 1'b0;
      line_cnt  <= 5'd0;
    end else begin
      cntr_ir_q <= cntr_ir;
      if (clr)
        line_cnt <= 5'd0;
      else if (en && cntr_ir && !cntr_ir_q)
        line_cnt <= line_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/cmd_proc.sv
// Command processor: decodes UART commands, runs calibration and heading/ramp moves, sends ACK/NACK.
// Build option FAST_SIM_EN (see cmd_proc_pkg) shortens the speed ramps.
module cmd_proc
  import cmd_proc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic        cal_done,
  input  logic [11:0] error,
  input  logic        cntrIR,
  output logic        strt_cal,
  output logic [11:0] dsrd_hdng,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        send_resp,
  output logic [7:0]  resp
);

  state_e      state, state_nxt;
  logic [3:0]  squares;
  logic [4:0]  line_cnt;
  logic        load_hdng;
  logic        strt_cal_nxt;
  logic        resp_req;
  logic [7:0]  resp_val;
  logic        resp_pend;
  logic [7:0]  pend_val;
  logic        err_ok;
  logic        at_target;

  assign moving    = (state == HEAD) || (state == RAMP_UP) || (state == RAMP_DN);
  assign err_ok    = ($signed(error) < HDNG_TOL) && ($signed(error) > -HDNG_TOL);
  assign at_target = (line_cnt == {squares, 1'b0});

  cmd_line_cnt u_line_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (load_hdng),
    .en      (moving),
    .cntr_ir (cntrIR),
    .line_cnt(line_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    clr_cmd_rdy  = 1'b0;
    strt_cal_nxt = 1'b0;
    load_hdng    = 1'b0;
    resp_req     = 1'b0;
    resp_val     = RESP_ACK;
    case (state)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          if (cmd[15:12] == OP_CAL) begin
            strt_cal_nxt = 1'b1;
            state_nxt    = CAL;
          end else if (cmd[15:12] == OP_HEAD) begin
            load_hdng = 1'b1;
            state_nxt = HEAD;
          end else begin
            resp_req = 1'b1;
            resp_val = RESP_NACK;
          end
        end
      end
      CAL: begin
        if (cal_done) begin
          resp_req  = 1'b1;
          state_nxt = IDLE;
        end
      end
      HEAD: begin
        // A zero-square move is just a turn, so it finishes once aligned.
        if (err_ok) begin
          if (squares == 4'd0) begin
            resp_req  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RAMP_UP;
          end
        end
      end
      RAMP_UP: begin
        if (at_target)
          state_nxt = RAMP_DN;
      end
      RAMP_DN: begin
        if (frwrd == 10'd0) begin
          resp_req  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frwrd     <= 10'd0;
      dsrd_hdng <= 12'h000;
      squares   <= 4'd0;
      strt_cal  <= 1'b0;
    end else begin
      strt_cal <= strt_cal_nxt;
      if (load_hdng) begin
        dsrd_hdng <= hdng_decode(cmd[11:4]);
        squares   <= cmd[3:0];
      end
      case (state)
        RAMP_UP: frwrd <= (frwrd > FRWRD_MAX - FRWRD_INC) ? FRWRD_MAX : frwrd + FRWRD_INC;
        RAMP_DN: frwrd <= (frwrd < FRWRD_DEC) ? 10'd0 : frwrd - FRWRD_DEC;
        default: frwrd <= 10'd0;
      endcase
    end
  end

  // A response requested right behind another pulse waits one cycle in a
  // single-entry holding slot so send_resp never stays high twice in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_resp <= 1'b0;
      resp      <= RESP_ACK;
      resp_pend <= 1'b0;
      pend_val  <= RESP_ACK;
    end else begin
      send_resp <= 1'b0;
      if (!send_resp && (resp_pend || resp_req)) begin
        send_resp <= 1'b1;
        resp      <= resp_pend ? pend_val : resp_val;
        resp_pend <= resp_pend && resp_req;
        if (resp_pend && resp_req)
          pend_val <= resp_val;
      end else if (resp_req) begin
        resp_pend <= 1'b1;
        pend_val  <= resp_val;
      end
    end
  end

endmodule

// File: tb/tb_cmd_proc.sv
// Self-checking bench for cmd_proc: a cycle vector table plus directed multi-cycle sequences.
module tb_cmd_proc;

  localparam logic [9:0] FMAX = 10'h2A0;
`ifdef FAST_SIM_EN
  localparam int INC = 32;
`else
  localparam int INC = 3;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cal_done;
  logic [11:0] error;
  logic        cntrIR;
  logic        strt_cal;
  logic [11:0] dsrd_hdng;
  logic [9:0]  frwrd;
  logic        moving;
  logic        send_resp;
  logic [7:0]  resp;

  int num_checks = 0;
  int num_fail   = 0;

  cmd_proc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cal_done   (cal_done),
    .error      (error),
    .cntrIR     (cntrIR),
    .strt_cal   (strt_cal),
    .dsrd_hdng  (dsrd_hdng),
    .frwrd      (frwrd),
    .moving     (moving),
    .send_resp  (send_resp),
    .resp       (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [11:0] error;
    logic        exp_clr;
    logic        exp_strt;
    logic        exp_send;
    logic [7:0]  exp_resp;
    logic        exp_moving;
    logic [11:0] exp_hdng;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic applyStimulus(input logic [15:0] c, input logic rdy, input logic cd,
                               input logic [11:0] err, input logic ir);
    cmd      = c;
    cmd_rdy  = rdy;
    cal_done = cd;
    error    = err;
    cntrIR   = ir;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(16'h0000, 1'b0, 1'b0, 12'h000, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [9:0] sat_up(input logic [9:0] v);
    int t;
    t = int'(v) + INC;
    return (t > int'(FMAX)) ? FMAX : 10'(t);
  endfunction

  function automatic logic [9:0] sat_dn(input logic [9:0] v);
    int t;
    t = int'(v) - 2 * INC;
    return (t < 0) ? 10'd0 : 10'(t);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] m;
    int         errs, sends, bad, clr_bad;
    bit         reached, started, zero_seen, ack_seen;

    vecs[0]  = '{16'h0000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 12'h000};
    vecs[1]  = '{16'h9000, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 12'h000};
    vecs[2]  = '{16'h9000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 12'h000};
    vecs[3]  = '{16'h9000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 12'h000};
    vecs[4]  = '{16'h0000, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 12'h000};
    vecs[5]  = '{16'h4000, 1'b1, 12'h100, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 12'h000};
    vecs[6]  = '{16'h4000, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 12'h000};
    vecs[7]  = '{16'h4000, 1'b0, 12'hF00, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 12'h000};
    vecs[8]  = '{16'h4000, 1'b0, 12'h030, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 12'h000};
    vecs[9]  = '{16'h4000, 1'b0, 12'hFD0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 12'h000};
    vecs[10] = '{16'h4000, 1'b0, 12'hFD1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 12'h000};
    vecs[11] = '{16'h4000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 12'h000};
    vecs[12] = '{16'h4A52, 1'b1, 12'h100, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 12'h000};
    vecs[13] = '{16'h4A52, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 12'hA5F};
    vecs[14] = '{16'h9000, 1'b1, 12'h100, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 12'hA5F};
    vecs[15] = '{16'h9000, 1'b1, 12'h100, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 12'hA5F};

    // Reset values while rst_n is held low
    applyStimulus(16'h0000, 1'b0, 1'b0, 12'h000, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_frwrd", frwrd, 10'd0);
    checkOutput("rst_hdng", dsrd_hdng, 12'h000);
    checkOutput("rst_send", send_resp, 1'b0);
    checkOutput("rst_strt", strt_cal, 1'b0);
    checkOutput("rst_clr", clr_cmd_rdy, 1'b0);
    checkOutput("rst_resp", resp, 8'hA5);
    checkOutput("rst_moving", moving, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      next_cycle();
      applyStimulus(vecs[i].cmd, vecs[i].cmd_rdy, 1'b0, vecs[i].error, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_clr", i), clr_cmd_rdy, vecs[i].exp_clr);
      checkOutput($sformatf("v%0d_strt", i), strt_cal, vecs[i].exp_strt);
      checkOutput($sformatf("v%0d_send", i), send_resp, vecs[i].exp_send);
      checkOutput($sformatf("v%0d_resp", i), resp, vecs[i].exp_resp);
      checkOutput($sformatf("v%0d_moving", i), moving, vecs[i].exp_moving);
      checkOutput($sformatf("v%0d_hdng", i), dsrd_hdng, vecs[i].exp_hdng);
      checkOutput($sformatf("v%0d_frwrd", i), frwrd, 10'd0);
    end

    // Calibration: strt_cal pulse, then ACK after cal_done
    do_reset();
    next_cycle();
    applyStimulus(16'h2000, 1'b1, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    checkOutput("cal_clr", clr_cmd_rdy, 1'b1);
    checkOutput("cal_strt_early", strt_cal, 1'b0);
    next_cycle();
    applyStimulus(16'h2000, 1'b0, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    checkOutput("cal_strt", strt_cal, 1'b1);
    sends = 0;
    bad   = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      if (send_resp) sends++;
      if (strt_cal) bad++;
    end
    checkOutput("cal_no_early_resp", sends, 0);
    checkOutput("cal_strt_single", bad, 0);
    next_cycle();
    cal_done = 1'b1;
    @(negedge clk);
    checkOutput("cal_send_wait", send_resp, 1'b0);
    next_cycle();
    cal_done = 1'b0;
    @(negedge clk);
    checkOutput("cal_send", send_resp, 1'b1);
    checkOutput("cal_resp", resp, 8'hA5);
    next_cycle();
    @(negedge clk);
    checkOutput("cal_send_end", send_resp, 1'b0);

    // Full move: ramp to max, four lines, ramp down, ACK
    do_reset();
    next_cycle();
    applyStimulus(16'h43F2, 1'b1, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    checkOutput("mv_clr", clr_cmd_rdy, 1'b1);
    next_cycle();
    applyStimulus(16'h43F2, 1'b0, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    checkOutput("mv_hdng", dsrd_hdng, 12'h3FF);
    checkOutput("mv_moving", moving, 1'b1);
    m = 10'd0; reached = 1'b0; errs = 0; sends = 0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      next_cycle();
      @(negedge clk);
      if (send_resp) sends++;
      if (!(m == 10'd0 && frwrd == 10'd0)) begin
        m = sat_up(m);
        if (frwrd != m) errs++;
      end
      if (frwrd == FMAX) reached = 1'b1;
    end
    checkOutput("mv_up_reached", reached, 1'b1);
    checkOutput("mv_up_steps", errs, 0);
    repeat (5) next_cycle();
    @(negedge clk);
    checkOutput("mv_up_saturate", frwrd, FMAX);
    for (int p = 0; p < 4; p++) begin
      next_cycle();
      cntrIR = 1'b1;
      @(negedge clk);
      if (send_resp) sends++;
      next_cycle();
      cntrIR = 1'b0;
      @(negedge clk);
      if (send_resp) sends++;
      next_cycle();
      @(negedge clk);
      if (send_resp) sends++;
      if (p == 2) checkOutput("mv_no_early_dn", frwrd, FMAX);
    end
    started = 1'b0; zero_seen = 1'b0; ack_seen = 1'b0; errs = 0;
    for (int i = 0; i < 1000 && !ack_seen; i++) begin
      next_cycle();
      @(negedge clk);
      if (!started && frwrd == FMAX) begin
        if (send_resp) sends++;
      end else begin
        started = 1'b1;
        m = sat_dn(m);
        if (frwrd != m) errs++;
        if (frwrd == 10'd0) zero_seen = 1'b1;
        if (send_resp) begin
          ack_seen = 1'b1;
          checkOutput("mv_ack_resp", resp, 8'hA5);
          checkOutput("mv_ack_moving", moving, 1'b0);
        end
      end
    end
    checkOutput("mv_dn_steps", errs, 0);
    checkOutput("mv_dn_zero", zero_seen, 1'b1);
    checkOutput("mv_ack_seen", ack_seen, 1'b1);
    checkOutput("mv_no_early_resp", sends, 0);
    next_cycle();
    @(negedge clk);
    checkOutput("mv_send_end", send_resp, 1'b0);

    // Heading error held out of tolerance, then brought inside
    do_reset();
    next_cycle();
    applyStimulus(16'h4000, 1'b1, 1'b0, 12'h100, 1'b0);
    @(negedge clk);
    checkOutput("hd_clr", clr_cmd_rdy, 1'b1);
    bad = 0; sends = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      applyStimulus(16'h4000, 1'b0, 1'b0, 12'h100, 1'b0);
      @(negedge clk);
      if (!moving || frwrd != 10'd0) bad++;
      if (send_resp) sends++;
    end
    checkOutput("hd_hold", bad, 0);
    checkOutput("hd_no_resp", sends, 0);
    next_cycle();
    error = 12'h010;
    @(negedge clk);
    checkOutput("hd_send_wait", send_resp, 1'b0);
    next_cycle();
    @(negedge clk);
    checkOutput("hd_send", send_resp, 1'b1);
    checkOutput("hd_resp", resp, 8'hA5);
    checkOutput("hd_moving", moving, 1'b0);
    checkOutput("hd_no_ramp", frwrd, 10'd0);

    // Reset asserted during RAMP_UP
    do_reset();
    next_cycle();
    applyStimulus(16'h4102, 1'b1, 1'b0, 12'h000, 1'b0);
    next_cycle();
    cmd_rdy = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      next_cycle();
      @(negedge clk);
      if (frwrd >= 10'h030) reached = 1'b1;
    end
    checkOutput("rr_ramping", reached, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rr_frwrd", frwrd, 10'd0);
    checkOutput("rr_moving", moving, 1'b0);
    checkOutput("rr_send", send_resp, 1'b0);
    checkOutput("rr_hdng", dsrd_hdng, 12'h000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sends = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      @(negedge clk);
      if (send_resp) sends++;
    end
    checkOutput("rr_no_resp", sends, 0);

    // cmd_rdy during a move is held off until IDLE, then taken
    do_reset();
    next_cycle();
    applyStimulus(16'h4012, 1'b1, 1'b0, 12'h000, 1'b0);
    next_cycle();
    cmd_rdy = 1'b0;
    repeat (10) next_cycle();
    applyStimulus(16'h9000, 1'b1, 1'b0, 12'h000, 1'b0);
    clr_bad = 0;
    for (int p = 0; p < 8; p++) begin
      cntrIR = ~p[0];
      @(negedge clk);
      if (clr_cmd_rdy) clr_bad++;
      next_cycle();
    end
    cntrIR = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 1000 && !reached; i++) begin
      @(negedge clk);
      if (!moving) reached = 1'b1;
      else begin
        if (clr_cmd_rdy) clr_bad++;
        next_cycle();
      end
    end
    checkOutput("mm_idle_reached", reached, 1'b1);
    checkOutput("mm_clr_held", clr_bad, 0);
    checkOutput("mm_accept", clr_cmd_rdy, 1'b1);
    checkOutput("mm_ack", send_resp, 1'b1);
    checkOutput("mm_ack_resp", resp, 8'hA5);
    next_cycle();
    cmd_rdy = 1'b0;
    @(negedge clk);
    checkOutput("mm_gap", send_resp, 1'b0);
    next_cycle();
    @(negedge clk);
    checkOutput("mm_nack", send_resp, 1'b1);
    checkOutput("mm_nack_resp", resp, 8'h5A);
    next_cycle();
    @(negedge clk);
    checkOutput("mm_nack_end", send_resp, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/cmd_proc.md
CMD_PROC -- requirements
Module: cmd_proc

Interface
REQ-001 SHALL have port clk, input, 1, system clock; one clock domain.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port cmd, input, 16, command word from the UART command receiver; [15:12] opcode, [11:4] heading code, [3:0] square count.
REQ-004 SHALL have port cmd_rdy, input, 1, high while cmd is valid.
REQ-005 SHALL have port clr_cmd_rdy, output, 1, one-cycle pulse that consumes the command.
REQ-006 SHALL have port cal_done, input, 1, calibration complete from the heading unit.
REQ-007 SHALL have port error, input, 12, signed heading error.
REQ-008 SHALL have port cntrIR, input, 1, centre line sensor, already synchronous to clk.
REQ-009 SHALL have port strt_cal, output, 1, one-cycle calibration start pulse.
REQ-010 SHALL have port dsrd_hdng, output, 12, desired heading.
REQ-011 SHALL have port frwrd, output, 10, forward speed.
REQ-012 SHALL have port moving, output, 1, high in HEAD, RAMP_UP and RAMP_DN.
REQ-013 SHALL have port send_resp, output, 1, one-cycle transmit pulse.
REQ-014 SHALL have port resp, output, 8, response byte: 8'hA5 for ACK, 8'h5A for NACK.

Function
REQ-015 SHALL implement a state machine with states IDLE, CAL, HEAD, RAMP_UP, RAMP_DN.
REQ-016 In IDLE with cmd_rdy=1, the block SHALL pulse clr_cmd_rdy in the same cycle and decode the opcode.
REQ-017 Opcode 4'h2 SHALL pulse strt_cal and go to CAL.
REQ-018 Opcode 4'h4 SHALL load dsrd_hdng and the square count, clear the line count, and go to HEAD.
REQ-019 Any other opcode SHALL drive resp=8'h5A, pulse send_resp one cycle later, and remain in IDLE.
REQ-020 dsrd_hdng SHALL be 12'h000 when cmd[11:4]=0; otherwise it SHALL be {cmd[11:4],4'hF}.
REQ-021 CAL: when cal_done=1, the block SHALL set resp=8'hA5, pulse send_resp, and go to IDLE.
REQ-022 HEAD: when |error| < 12'h030 (signed compare), the block SHALL go to RAMP_UP; if the square count is 0, it SHALL instead send ACK and go to IDLE.
REQ-023 RAMP_UP: frwrd SHALL increase by FRWRD_INC each cycle, saturating at FRWRD_MAX=10'h2A0 with no overflow.
REQ-024 Each rising edge of cntrIR (prior-cycle register) SHALL increment the line count while moving.
REQ-025 When line count == 2*squares, the block SHALL go to RAMP_DN, including when this occurs mid-ramp.
REQ-026 RAMP_DN: frwrd SHALL decrease by 2*FRWRD_INC per cycle, floored at 0 with no underflow.
REQ-027 When frwrd reaches 0 in RAMP_DN, the block SHALL send ACK and go to IDLE.
REQ-028 cmd_rdy outside IDLE SHALL be ignored, with clr_cmd_rdy held low; the command SHALL be accepted on the first IDLE cycle.
REQ-029 send_resp SHALL never be asserted in two consecutive cycles.

Reset
REQ-030 On rst_n low, the block SHALL go to IDLE immediately, including mid-operation.
REQ-031 On reset, frwrd, dsrd_hdng, line count, strt_cal, send_resp and clr_cmd_rdy SHALL be 0, and resp SHALL be 8'hA5.
REQ-032 No response SHALL be sent for a command aborted by reset.

Configuration
REQ-033 With FAST_SIM_EN defined, FRWRD_INC SHALL be 10'h020; without it, FRWRD_INC SHALL be 10'h003.

Structure
REQ-034 Package cmd_proc_pkg SHALL hold the opcode enum, state enum, FRWRD_MAX, heading tolerance, ACK/NACK constants and FRWRD_INC selection.
REQ-035 Line counting (edge detect plus 5-bit counter with clear) SHALL be the sub-module cmd_line_cnt.

Verification
REQ-036 The bench SHALL drive cmd=16'h2000 with cmd_rdy, then cal_done after 10 cycles, and SHALL check: strt_cal pulse, then send_resp with resp=8'hA5.
REQ-037 The bench SHALL drive cmd=16'h43F2 with error=12'h000 and four cntrIR pulses, and SHALL check: dsrd_hdng=12'h3FF; frwrd ramps to 10'h2A0, ramps down to 0; then ACK.
REQ-038 The bench SHALL drive cmd=16'h9000, and SHALL check: clr_cmd_rdy pulse, resp=8'h5A, a single send_resp, state IDLE.
REQ-039 The bench SHALL drive cmd=16'h4000 with error=12'h100 held for 20 cycles, then error=12'h010, and SHALL check: no ramp; ACK follows once the error is within tolerance.
REQ-040 The bench SHALL assert rst_n=0 during RAMP_UP, and SHALL check: frwrd=0 and IDLE the same cycle, with no send_resp.
REQ-041 The bench SHALL assert cmd_rdy mid-move, and SHALL check: clr_cmd_rdy is held low until IDLE, then the command is accepted.
